instruction_fetch: RTL and testbench

Fetch stage of the single-issue MIPS datapath: holds the program counter, fetches 32-bit instructions from instruction memory over a request/acknowledge handshake, and presents them in an IF/ID register whose `opcode` field drives the main control decoder. It absorbs decode-side stalls with a one-entry skid buffer and flushes on taken branches (`branch & zero` resolved downstream).

---
 rtl/instruction_fetch.sv | 191 +++++++++++++++++++
 tb/tb_instruction_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, imem request/ack fetch, IF/ID register with one-entry skid buffer.
// Optional: define INSTRUCTION_FETCH_ALIGN_CHECK_EN to add alignErr and a HALT state.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   imemReq, imemAddr     fetch request (held until imemAck)
//   imemAck, imemData     fetch response
//   stall                 decode cannot accept; IF/ID holds
//   redirect, redirectTarget  taken branch: flush and refetch at target
//   instrValid, instr, opcode, pcPlus4  IF/ID register contents
//   alignErr              (macro only) sticky misaligned-redirect flag
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
    output logic        alignErr,
`endif
    output logic [31:0] pcPlus4
);

`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {IDLE, WAIT, HOLD, DRAIN, HALT} fetchStateT;
`else
    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} fetchStateT;
`endif

    fetchStateT  state;
    logic [31:0] pc;
    logic [31:0] skidInstr;
    logic [31:0] skidPc4;

    logic [31:0] pcNext4;
    logic [31:0] target;
    logic        ifIdFree;
    logic        badTarget;
    logic        haltNow;

    assign pcNext4  = pc + 32'd4;
    // Low address bits are dropped; with the check enabled a nonzero
    // value halts the stage instead of being fetched.
    assign target   = redirectTarget & 32'hFFFF_FFFC;
    assign ifIdFree = !instrValid || !stall;
    assign opcode   = instr[31:26];

`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
    assign badTarget = redirect && (redirectTarget[1:0] != 2'b00);
    // A halt decided earlier (during a drain) is remembered in alignErr.
    assign haltNow   = badTarget || alignErr;
`else
    assign badTarget = 1'b0;
    assign haltNow   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imemReq    <= 1'b0;
            imemAddr   <= RESET_PC;
            instrValid <= 1'b0;
            instr      <= 32'h0;
            pcPlus4    <= 32'h0;
            skidInstr  <= 32'h0;
            skidPc4    <= 32'h0;
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
            alignErr   <= 1'b0;
`endif
        end else begin
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
            if (badTarget && state != IDLE && state != HALT)
                alignErr <= 1'b1;
`endif
            unique case (state)
                IDLE: begin
                    state    <= WAIT;
                    imemReq  <= 1'b1;
                    imemAddr <= pc;
                end

                WAIT: begin
                    if (redirect) begin
                        instrValid <= 1'b0;
                        pc         <= target;
                        if (imemAck) begin
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
                            if (haltNow) begin
                                state   <= HALT;
                                imemReq <= 1'b0;
                            end else
`endif
                            begin
                                state    <= WAIT;
                                imemAddr <= target;
                            end
                        end else begin
                            // Request in flight: keep it up until acked.
                            state <= DRAIN;
                        end
                    end else if (imemAck) begin
                        pc <= pcNext4;
                        if (ifIdFree) begin
                            instr      <= imemData;
                            pcPlus4    <= pcNext4;
                            instrValid <= 1'b1;
                            imemAddr   <= pcNext4;
                        end else begin
                            skidInstr <= imemData;
                            skidPc4   <= pcNext4;
                            imemReq   <= 1'b0;
                            state     <= HOLD;
                        end
                    end else if (!stall) begin
                        instrValid <= 1'b0;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        instrValid <= 1'b0;
                        skidInstr  <= 32'h0;
                        skidPc4    <= 32'h0;
                        pc         <= target;
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
                        if (haltNow) begin
                            state <= HALT;
                        end else
`endif
                        begin
                            state    <= WAIT;
                            imemReq  <= 1'b1;
                            imemAddr <= target;
                        end
                    end else if (!stall) begin
                        instr      <= skidInstr;
                        pcPlus4    <= skidPc4;
                        instrValid <= 1'b1;
                        skidInstr  <= 32'h0;
                        skidPc4    <= 32'h0;
                        state      <= WAIT;
                        imemReq    <= 1'b1;
                        imemAddr   <= pc;
                    end
                end

                DRAIN: begin
                    instrValid <= 1'b0;
                    if (redirect)
                        pc <= target;
                    // The drained word belongs to the flushed path.
                    if (imemAck) begin
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
                        if (haltNow) begin
                            state   <= HALT;
                            imemReq <= 1'b0;
                        end else
`endif
                        begin
                            state    <= WAIT;
                            imemAddr <= redirect ? target : pc;
                        end
                    end
                end

`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
                HALT: begin
                    imemReq    <= 1'b0;
                    instrValid <= 1'b0;
                end
`endif

                default: begin
                    state   <= IDLE;
                    imemReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed cycle table plus randomized run against a
// program-order reference model of the fetch stage.
module tb_instruction_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic        ackEn;
    logic [31:0] redirectTarget;
    logic        imemReq;
    logic        imemAck;
    logic        instrValid;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic [5:0]  opcode;
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
    logic        alignErr;
    logic        bAlign;
`endif

    logic        bReq;
    logic        bValid;
    logic [31:0] bAddr;
    logic [31:0] bData;
    logic [31:0] bInstr;
    logic [31:0] bPc4;
    logic [5:0]  bOp;

    int nVec = 0;
    int nErr = 0;

    // Instruction memory contents: distinct word per address.
    function automatic logic [31:0] memFn(input logic [31:0] a);
        if (a == 32'h0)      return 32'h8C01_0004;
        else if (a == 32'h4) return 32'h0022_1820;
        else                 return {6'b000010, a[27:2]};
    endfunction

    assign imemAck  = imemReq & ackEn;
    assign imemData = memFn(imemAddr);
    assign bData    = memFn(bAddr);

    instruction_fetch dut (
        .clk(clk),
        .rst_n(rst_n),
        .imemReq(imemReq),
        .imemAddr(imemAddr),
        .imemAck(imemAck),
        .imemData(imemData),
        .stall(stall),
        .redirect(redirect),
        .redirectTarget(redirectTarget),
        .instrValid(instrValid),
        .instr(instr),
        .opcode(opcode),
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
        .alignErr(alignErr),
`endif
        .pcPlus4(pcPlus4)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk),
        .rst_n(rst_n),
        .imemReq(bReq),
        .imemAddr(bAddr),
        .imemAck(bReq),
        .imemData(bData),
        .stall(1'b0),
        .redirect(1'b0),
        .redirectTarget(32'h0),
        .instrValid(bValid),
        .instr(bInstr),
        .opcode(bOp),
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
        .alignErr(bAlign),
`endif
        .pcPlus4(bPc4)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rstN;
        logic        st;
        logic        rd;
        logic        ak;
        logic [31:0] tg;
        logic        eReq;
        logic        ca;
        logic [31:0] eAddr;
        logic        eValid;
        logic        cd;
        logic [31:0] eInstr;
        logic [31:0] ePc4;
        logic        eAlign;
    } vecT;

    function automatic vecT mk(
        input logic rstN, input logic st, input logic rd, input logic ak,
        input logic [31:0] tg, input logic eReq, input logic ca,
        input logic [31:0] eAddr, input logic eValid, input logic cd,
        input logic [31:0] eInstr, input logic [31:0] ePc4,
        input logic eAlign);
        vecT v;
        v.rstN = rstN; v.st = st; v.rd = rd; v.ak = ak; v.tg = tg;
        v.eReq = eReq; v.ca = ca; v.eAddr = eAddr; v.eValid = eValid;
        v.cd = cd; v.eInstr = eInstr; v.ePc4 = ePc4; v.eAlign = eAlign;
        return v;
    endfunction

    vecT         q[$];
    vecT         v;
    logic [31:0] expNext;
    logic        prevReq;
    logic        prevAck;
    logic [31:0] prevAddr;
    int          consumed;

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
        ackEn = 1'b0; redirectTarget = 32'h0;

        //       rst st rd ak target   req ca addr    vld cd instr          pc4    al
        q.push_back(mk(1,0,0,1,32'h0,   0,1,32'h0,   0,1,32'h0,        32'h0, 0));
        q.push_back(mk(1,0,0,1,32'h0,   1,1,32'h0,   0,0,32'h0,        32'h0, 0));
        q.push_back(mk(1,0,0,1,32'h0,   1,1,32'h4,   1,1,32'h8C010004, 32'h4, 0));
        q.push_back(mk(1,1,0,1,32'h0,   1,1,32'h8,   1,1,32'h00221820, 32'h8, 0));
        q.push_back(mk(1,1,0,1,32'h0,   0,0,32'h0,   1,1,32'h00221820, 32'h8, 0));
        q.push_back(mk(1,1,0,1,32'h0,   0,0,32'h0,   1,1,32'h00221820, 32'h8, 0));
        q.push_back(mk(1,0,0,0,32'h0,   0,0,32'h0,   1,1,32'h00221820, 32'h8, 0));
        q.push_back(mk(1,0,0,0,32'h0,   1,1,32'hC,   1,1,memFn(32'h8), 32'hC, 0));
        q.push_back(mk(1,0,1,0,32'h40,  1,1,32'hC,   0,0,32'h0,        32'h0, 0));
        q.push_back(mk(1,0,0,0,32'h0,   1,1,32'hC,   0,0,32'h0,        32'h0, 0));
        q.push_back(mk(1,0,0,0,32'h0,   1,1,32'hC,   0,0,32'h0,        32'h0, 0));
        q.push_back(mk(1,0,0,1,32'h0,   1,1,32'hC,   0,0,32'h0,        32'h0, 0));
        q.push_back(mk(1,0,0,1,32'h0,   1,1,32'h40,  0,0,32'h0,        32'h0, 0));
        q.push_back(mk(1,1,1,0,32'h80,  1,1,32'h44,  1,1,memFn(32'h40),32'h44,0));
        q.push_back(mk(1,0,0,1,32'h0,   1,1,32'h44,  0,0,32'h0,        32'h0, 0));
        q.push_back(mk(1,0,0,1,32'h0,   1,1,32'h80,  0,0,32'h0,        32'h0, 0));
        q.push_back(mk(1,0,1,1,32'h100, 1,1,32'h84,  1,1,memFn(32'h80),32'h84,0));
        q.push_back(mk(1,0,0,1,32'h0,   1,1,32'h100, 0,0,32'h0,        32'h0, 0));
        q.push_back(mk(1,0,1,1,32'h42,  1,1,32'h104, 1,1,memFn(32'h100),32'h104,0));
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
        q.push_back(mk(1,0,0,1,32'h0,   0,0,32'h0,   0,0,32'h0,        32'h0, 1));
        q.push_back(mk(1,0,1,1,32'h80,  0,0,32'h0,   0,0,32'h0,        32'h0, 1));
        q.push_back(mk(0,0,0,0,32'h0,   0,0,32'h0,   0,0,32'h0,        32'h0, 1));
        q.push_back(mk(1,0,0,0,32'h0,   0,1,32'h0,   0,1,32'h0,        32'h0, 0));
        q.push_back(mk(1,0,0,0,32'h0,   1,1,32'h0,   0,0,32'h0,        32'h0, 0));
`else
        q.push_back(mk(1,0,0,1,32'h0,   1,1,32'h40,  0,0,32'h0,        32'h0, 0));
        q.push_back(mk(0,0,0,0,32'h0,   1,1,32'h44,  1,1,memFn(32'h40),32'h44,0));
        q.push_back(mk(1,0,0,0,32'h0,   0,1,32'h0,   0,1,32'h0,        32'h0, 0));
        q.push_back(mk(1,0,0,0,32'h0,   1,1,32'h0,   0,0,32'h0,        32'h0, 0));
`endif

        repeat (2) @(posedge clk);

        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            v = q[i];
            chk($sformatf("row%0d imemReq", i), {31'h0, imemReq}, {31'h0, v.eReq});
            if (v.ca)
                chk($sformatf("row%0d imemAddr", i), imemAddr, v.eAddr);
            chk($sformatf("row%0d instrValid", i), {31'h0, instrValid},
                {31'h0, v.eValid});
            if (v.cd) begin
                chk($sformatf("row%0d instr", i), instr, v.eInstr);
                chk($sformatf("row%0d opcode", i), {26'h0, opcode},
                    {26'h0, v.eInstr[31:26]});
                chk($sformatf("row%0d pcPlus4", i), pcPlus4, v.ePc4);
            end
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
            chk($sformatf("row%0d alignErr", i), {31'h0, alignErr},
                {31'h0, v.eAlign});
`endif
            if (i == 1) begin
                chk("wrap first addr", bAddr, 32'hFFFF_FFFC);
                chk("wrap first req", {31'h0, bReq}, 32'h1);
            end
            if (i == 2) begin
                chk("wrap second addr", bAddr, 32'h0000_0000);
                chk("wrap pcPlus4", bPc4, 32'h0000_0000);
                chk("wrap valid", {31'h0, bValid}, 32'h1);
            end
            rst_n          = v.rstN;
            stall          = v.st;
            redirect       = v.rd;
            ackEn          = v.ak;
            redirectTarget = v.tg;
        end

        // Randomized run: decode must see the program in order from the
        // last redirect target, with no word lost or repeated.
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; ackEn = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        expNext  = 32'h0;
        prevReq  = 1'b0;
        prevAck  = 1'b0;
        prevAddr = 32'h0;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge clk);
            stall    = ($urandom_range(0, 99) < 30);
            redirect = (c != 0) && ($urandom_range(0, 99) < 4);
            ackEn    = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 7) == 0)
                redirectTarget = 32'hFFFF_FFF8;
            else
                redirectTarget = $urandom & 32'h0000_0FFF;
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
            redirectTarget[1:0] = 2'b00;
`endif
            #1;
            if (prevReq && !prevAck) begin
                chk("rand req held", {31'h0, imemReq}, 32'h1);
                chk("rand addr stable", imemAddr, prevAddr);
            end
            if (imemReq)
                chk("rand addr aligned", {30'h0, imemAddr[1:0]}, 32'h0);
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
            chk("rand alignErr", {31'h0, alignErr}, 32'h0);
`endif
            if (instrValid && !stall && !redirect) begin
                chk("rand instr", instr, memFn(expNext));
                chk("rand pcPlus4", pcPlus4, expNext + 32'd4);
                chk("rand opcode", {26'h0, opcode},
                    {26'h0, memFn(expNext) >> 26});
                expNext = expNext + 32'd4;
                consumed++;
            end
            if (redirect)
                expNext = redirectTarget & 32'hFFFF_FFFC;
            prevReq  = imemReq;
            prevAck  = imemAck;
            prevAddr = imemAddr;
        end
        chk("rand progress", {31'h0, consumed > 200}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
